// File: rtl/alu_share_arbiter.sv
// Purpose : round-robin share of the nibble-serial ALU between PC sequencer (port 0) and executor (port 1).
// Latency : req sampled in IDLE -> ack next cycle; done after (ALU busy cycles + 1, min 2) RUN cycles + 1.
// Backpr. : a requester holds req with stable args until ack; requests outside IDLE wait at req level.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req*/nib*/neg*/w1_*/w2_*/pre*  per-port request and operand set
//   ack*, done*                one-cycle pulses: args latched / result valid for that port
//   result                     last completed ALU result, held until next done
//   alu_*                      drive side of the shared ALU (perm, latched operands) and its busy/result

module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int NIBW  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [NIBW-1:0]  nib0,
    input  logic [NIBW-1:0]  nib1,
    input  logic             neg0,
    input  logic             neg1,
    input  logic [WIDTH-1:0] w1_0,
    input  logic [WIDTH-1:0] w1_1,
    input  logic [WIDTH-1:0] w2_0,
    input  logic [WIDTH-1:0] w2_1,
    input  logic [WIDTH-1:0] pre0,
    input  logic [WIDTH-1:0] pre1,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             alu_perm_to_count,
    output logic [NIBW-1:0]  alu_nibbles,
    output logic             alu_w2_neg,
    output logic [WIDTH-1:0] alu_w1,
    output logic [WIDTH-1:0] alu_w2,
    output logic [WIDTH-1:0] alu_preinit,
    input  logic             alu_busy,
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q,    state_d;
    logic             gnt_q,      gnt_d;
    logic             last_gnt_q, last_gnt_d;
    logic             saw_busy_q, saw_busy_d;
    logic [1:0]       wcnt_q,     wcnt_d;
    logic [NIBW-1:0]  nib_q,      nib_d;
    logic             neg_q,      neg_d;
    logic [WIDTH-1:0] w1_q,       w1_d;
    logic [WIDTH-1:0] w2_q,       w2_d;
    logic [WIDTH-1:0] pre_q,      pre_d;
    logic [WIDTH-1:0] result_q,   result_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;     // port 0 wins the first contested grant
            saw_busy_q <= 1'b0;
            wcnt_q     <= 2'd0;
            nib_q      <= '0;
            neg_q      <= 1'b0;
            w1_q       <= '0;
            w2_q       <= '0;
            pre_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            saw_busy_q <= saw_busy_d;
            wcnt_q     <= wcnt_d;
            nib_q      <= nib_d;
            neg_q      <= neg_d;
            w1_q       <= w1_d;
            w2_q       <= w2_d;
            pre_q      <= pre_d;
            result_q   <= result_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        gnt_d             = gnt_q;
        last_gnt_d        = last_gnt_q;
        saw_busy_d        = saw_busy_q;
        wcnt_d            = wcnt_q;
        nib_d             = nib_q;
        neg_d             = neg_q;
        w1_d              = w1_q;
        w2_d              = w2_q;
        pre_d             = pre_q;
        result_d          = result_q;
        ack0              = 1'b0;
        ack1              = 1'b0;
        done0             = 1'b0;
        done1             = 1'b0;
        alu_perm_to_count = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // Contested: the port not served last time wins.
                    gnt_d   = (req0 && req1) ? ~last_gnt_q : req1;
                    nib_d   = gnt_d ? nib1 : nib0;
                    neg_d   = gnt_d ? neg1 : neg0;
                    w1_d    = gnt_d ? w1_1 : w1_0;
                    w2_d    = gnt_d ? w2_1 : w2_0;
                    pre_d   = gnt_d ? pre1 : pre0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                ack0              = ~gnt_q;
                ack1              = gnt_q;
                alu_perm_to_count = 1'b1;
                saw_busy_d        = 1'b0;
                wcnt_d            = 2'd0;
                state_d           = S_RUN;
            end
            S_RUN: begin
                alu_perm_to_count = 1'b1;
                if (alu_busy) begin
                    saw_busy_d = 1'b1;
                end
                // Count idle RUN cycles only until the ALU has shown busy.
                if (!saw_busy_q && !alu_busy) begin
                    wcnt_d = wcnt_q + 2'd1;
                end
                // Finish on busy falling, or after two idle cycles when the
                // ALU completed the op without ever raising busy.
                if (!alu_busy && (saw_busy_q || wcnt_q == 2'd1)) begin
                    result_d = alu_result;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                done0      = ~gnt_q;
                done1      = gnt_q;
                last_gnt_d = gnt_q;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign result      = result_q;
    assign alu_nibbles = nib_q;
    assign alu_w2_neg  = neg_q;
    assign alu_w1      = w1_q;
    assign alu_w2      = w2_q;
    assign alu_preinit = pre_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose : exercise alu_share_arbiter against a transaction-timeline reference and an ALU stand-in.
// Latency : n/a (bench).
// Backpr. : requesters hold req with stable args until they see their ack.

module tb_alu_share_arbiter;

    localparam int W  = 32;
    localparam int NW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1;
    logic [NW-1:0] nib0, nib1;
    logic          neg0, neg1;
    logic [W-1:0]  w1_0, w1_1, w2_0, w2_1, pre0, pre1;
    logic          ack0, ack1, done0, done1;
    logic [W-1:0]  result;
    logic          alu_perm_to_count;
    logic [NW-1:0] alu_nibbles;
    logic          alu_w2_neg;
    logic [W-1:0]  alu_w1, alu_w2, alu_preinit;
    logic          alu_busy;
    logic [W-1:0]  alu_result;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(W), .NIBW(NW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .nib0(nib0), .nib1(nib1),
        .neg0(neg0), .neg1(neg1),
        .w1_0(w1_0), .w1_1(w1_1), .w2_0(w2_0), .w2_1(w2_1),
        .pre0(pre0), .pre1(pre1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .result(result),
        .alu_perm_to_count(alu_perm_to_count),
        .alu_nibbles(alu_nibbles), .alu_w2_neg(alu_w2_neg),
        .alu_w1(alu_w1), .alu_w2(alu_w2), .alu_preinit(alu_preinit),
        .alu_busy(alu_busy), .alu_result(alu_result)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ALU stand-in: busy for alu_lat cycles starting one cycle after perm
    // first rises, result appears as busy drops (or on the first RUN cycle
    // for a zero-latency op). Garbage is shown while the op is in flight.
    int alu_lat = 1;
    int tick;
    initial begin
        alu_busy   = 1'b0;
        alu_result = '0;
        tick       = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!alu_perm_to_count) begin
                tick     = 0;
                alu_busy = 1'b0;
            end else begin
                tick++;
                alu_busy = (tick >= 2) && (tick < 2 + alu_lat);
                if (tick == 1) alu_result = $urandom;
                if (tick == 2 + alu_lat) alu_result = alu_w1 + alu_w2;
            end
        end
    end

    // Reference: each service is a timeline of absolute cycle numbers.
    int           cyc = 0;
    bit           in_svc = 0;
    int           t_ack = 0, t_done = 0;
    bit           gnt = 0, last = 1;
    logic [W-1:0] h_w1 = '0, h_w2 = '0, h_pre = '0, exp_res = '0;
    logic [NW-1:0] h_nib = '0;
    bit           h_neg = 0;
    int           lat_fix = 1;

    // Check the current cycle, predict the coming edge, advance one cycle.
    task automatic step();
        bit e_ack, e_done, e_perm;
        int k;
        e_ack  = in_svc && (cyc == t_ack);
        e_done = in_svc && (cyc == t_done);
        e_perm = in_svc && (cyc >= t_ack) && (cyc < t_done);
        if (e_done) exp_res = h_w1 + h_w2;
        chk("ack0",  32'(ack0),  32'(e_ack && !gnt));
        chk("ack1",  32'(ack1),  32'(e_ack && gnt));
        chk("done0", 32'(done0), 32'(e_done && !gnt));
        chk("done1", 32'(done1), 32'(e_done && gnt));
        chk("perm",  32'(alu_perm_to_count), 32'(e_perm));
        chk("result", result, exp_res);
        chk("alu_w1", alu_w1, h_w1);
        chk("alu_w2", alu_w2, h_w2);
        chk("alu_pre", alu_preinit, h_pre);
        chk("alu_nib", 32'(alu_nibbles), 32'(h_nib));
        chk("alu_neg", 32'(alu_w2_neg), 32'(h_neg));
        if (e_done) last = gnt;

        if (!rst_n) begin
            in_svc = 0; last = 1; exp_res = '0;
            h_w1 = '0; h_w2 = '0; h_pre = '0; h_nib = '0; h_neg = 0;
        end else if ((!in_svc || cyc > t_done) && (req0 || req1)) begin
            gnt   = (req0 && req1) ? !last : req1;
            h_w1  = gnt ? w1_1 : w1_0;
            h_w2  = gnt ? w2_1 : w2_0;
            h_pre = gnt ? pre1 : pre0;
            h_nib = gnt ? nib1 : nib0;
            h_neg = gnt ? neg1 : neg0;
            alu_lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
            k = (alu_lat == 0) ? 2 : alu_lat + 1;
            t_ack  = cyc + 1;
            t_done = cyc + 2 + k;
            in_svc = 1;
        end else if (in_svc && cyc > t_done) begin
            in_svc = 0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    bit keep0 = 0, keep1 = 0;

    task automatic new_args(input bit p);
        if (!p) begin
            nib0 = NW'($urandom_range(0, 7)); neg0 = 1'($urandom);
            w1_0 = $urandom; w2_0 = $urandom; pre0 = $urandom;
        end else begin
            nib1 = NW'($urandom_range(0, 7)); neg1 = 1'($urandom);
            w1_1 = $urandom; w2_1 = $urandom; pre1 = $urandom;
        end
    endtask

    // Requesters: react to this cycle's ack, optionally raise new requests.
    task automatic drive(input bit auto_req);
        if (ack0) begin
            if (!keep0) req0 = 1'b0;
            new_args(1'b0);
        end
        if (ack1) begin
            if (!keep1) req1 = 1'b0;
            new_args(1'b1);
        end
        if (auto_req && !req0 && $urandom_range(0, 3) == 0) req0 = 1'b1;
        if (auto_req && !req1 && $urandom_range(0, 3) == 0) req1 = 1'b1;
    endtask

    int ack_order[$];
    int t_d0, t_a1, n_perm, n_ack1;
    bit seen_busy;

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        nib0 = '0; nib1 = '0; neg0 = 1'b0; neg1 = 1'b0;
        w1_0 = '0; w1_1 = '0; w2_0 = '0; w2_1 = '0; pre0 = '0; pre1 = '0;
        @(negedge clk);

        // Reset state.
        repeat (3) step();
        rst_n = 1'b1;

        // Single request on port 0, one busy cycle.
        lat_fix = 1;
        nib0 = 3'd0; neg0 = 1'b0; w1_0 = 32'hFF; w2_0 = 32'd4; pre0 = 32'hFF;
        req0 = 1'b1;
        repeat (8) begin drive(1'b0); step(); end
        chk("single_result", result, 32'h103);

        // Simultaneous requests straight after reset.
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        lat_fix = 2;
        new_args(1'b0); new_args(1'b1);
        w1_0 = 32'd123; w2_0 = 32'd2; w1_1 = 32'd5; w2_1 = 32'd7;
        req0 = 1'b1; req1 = 1'b1;
        t_d0 = -100; t_a1 = 0;
        repeat (20) begin
            if (done0) t_d0 = cyc;
            if (ack1)  t_a1 = cyc;
            drive(1'b0);
            step();
        end
        chk("both_gap", 32'(t_a1 - t_d0), 32'd2);
        chk("both_result", result, 32'd12);

        // Fairness with both requests held.
        keep0 = 1; keep1 = 1; lat_fix = -1;
        req0 = 1'b1; req1 = 1'b1;
        repeat (60) begin
            if (ack0) ack_order.push_back(0);
            if (ack1) ack_order.push_back(1);
            drive(1'b0);
            step();
        end
        keep0 = 0; keep1 = 0; req0 = 1'b0; req1 = 1'b0;
        repeat (10) step();
        chk("fair_count", 32'(ack_order.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < ack_order.size(); i++)
            chk("fair_order", 32'(ack_order[i]), 32'(i % 2));

        // Zero-latency ALU: LAUNCH + exactly two RUN cycles of perm.
        lat_fix = 0;
        new_args(1'b1);
        req1 = 1'b1;
        n_perm = 0;
        repeat (8) begin
            if (alu_perm_to_count) n_perm++;
            drive(1'b0);
            step();
        end
        chk("zero_lat_perm", 32'(n_perm), 32'd3);

        // Operand stability while the op runs.
        lat_fix = 3;
        new_args(1'b0);
        w1_0 = 32'h10; w2_0 = 32'd5;
        req0 = 1'b1;
        repeat (10) begin
            if (ack0) begin req0 = 1'b0; w1_0 = 32'h20; end
            if (alu_perm_to_count && !ack0) chk("stable_w1", alu_w1, 32'h10);
            step();
        end
        chk("stable_result", result, 32'h15);

        // Reset while the ALU is busy.
        lat_fix = 3;
        new_args(1'b0);
        req0 = 1'b1;
        seen_busy = 0;
        for (int i = 0; i < 10 && !seen_busy; i++) begin
            if (ack0) req0 = 1'b0;
            step();
            seen_busy = alu_busy;
        end
        chk("midrun_busy_seen", 32'(seen_busy), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrun_perm", 32'(alu_perm_to_count), 32'd0);
        chk("midrun_result", result, 32'd0);
        repeat (6) step();
        lat_fix = 1;
        new_args(1'b1);
        req1 = 1'b1;
        n_ack1 = 0;
        repeat (8) begin
            if (ack1) n_ack1++;
            drive(1'b0);
            step();
        end
        chk("post_reset_ack1", 32'(n_ack1), 32'd1);

        // Random traffic with occasional resets.
        lat_fix = -1;
        repeat (2000) begin
            drive(1'b1);
            rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            step();
        end
        rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single nibble-serial ALU (`loopOverAllNibbles`) between two requesters: the PC-increment sequencer (port 0) and the instruction executor (port 1). It arbitrates round-robin, latches the winning operand set, and drives the ALU's count-permission, operands and nibble count. It waits for the ALU's `busy` handshake to complete, then returns the result to the granted requester with a one-cycle done pulse. It sits between `control` and the ALU instance, replacing the direct `setAluArgs` wiring.

## Interface
- `WIDTH`, 32, operand/result width
- `NIBW`, 3, width of nibble-count field (last nibble index)

- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req0`, `req1`  in  1  request; held high with stable args until ack
- `nib0`, `nib1`  in  NIBW  last nibble index (0 = increment, 7 = 32-bit)
- `neg0`, `neg1`  in  1  word2 is signed and negative
- `w1_0`, `w1_1`, `w2_0`, `w2_1`  in  WIDTH  operands
- `pre0`, `pre1`  in  WIDTH  preinit result
- `ack0`, `ack1`  out  1  one-cycle pulse: request accepted, args latched
- `done0`, `done1`  out  1  one-cycle pulse: `result` valid for this port
- `result`  out  WIDTH  last completed ALU result, held until next done
- `alu_perm_to_count`  out  1  ALU permission to count
- `alu_nibbles`  out  NIBW  latched nibble index
- `alu_w2_neg`  out  1  latched sign flag
- `alu_w1`, `alu_w2`, `alu_preinit`  out  WIDTH  latched operands
- `alu_busy`  in  1  ALU busy
- `alu_result`  in  WIDTH  ALU result

## Operation
- States: IDLE, LAUNCH, RUN, DONE.
- IDLE: if no req, stay. If exactly one req, grant it. If both, grant the port not granted last time. After reset, priority goes to port 0. On the edge, latch the winner's nib/neg/w1/w2/pre into holding registers, record `gnt`, and go to LAUNCH.
- LAUNCH: `ack[gnt]`=1 and `alu_perm_to_count`=1 for one cycle. Clear `saw_busy` and the 2-bit wait counter. Go to RUN.
- RUN: `alu_perm_to_count`=1.
  - `alu_busy`=1 sets `saw_busy`.
  - Exit to DONE when `alu_busy`=0 and `saw_busy`=1.
  - Also exit when `alu_busy` has stayed 0 for 2 RUN cycles (zero-latency op).
  - The wait counter increments only while `saw_busy`=0.
- DONE: `perm`=0. On entry edge, `result`<=`alu_result`. `done[gnt]`=1 for one cycle. `last_gnt`<=`gnt`. Go to IDLE.
- A req still high in IDLE after its done is a new request. Round-robin ensures the other port wins if it is pending.
- ALU outputs always show the holding registers. They change only on the IDLE→LAUNCH edge.
- Requests arriving during LAUNCH/RUN/DONE are ignored until IDLE. No queueing beyond the req level.
- Reset (`rst_n`=0 at any edge, including mid-RUN):
  - state IDLE; `last_gnt`=1, so port 0 wins first.
  - all acks/dones/perm = 0.
  - `result`=0; holding registers = 0.
  - The in-flight op is abandoned with no done.

## Timing
- Request to ack: req sampled high in IDLE at edge N, ack high during cycle N+1 (LAUNCH).
- Minimum turnaround: IDLE, LAUNCH, RUN×k, DONE, IDLE. With k = ALU busy cycles + 1, a new grant is possible at the edge after DONE.
- `done` and the new `result` are visible in the same cycle.
- Back-to-back: a port with req held continuously gets its next ack 2 cycles after its done, provided the other port is idle.
- Outputs are registered or decoded from state only. There is no combinational path from req to ack.

## Test plan
- Single request: port 0 with `nib0`=0, `w1_0`=0xFF, `w2_0`=4, `pre0`=0xFF; ALU model busy for 1 cycle, result 0x103 → ack0 at cycle 1, perm high in LAUNCH and RUN, done0 pulse with `result`=0x103, `ack1`/`done1` stay 0.
- Simultaneous requests right after reset: port 0 (w1=123, w2=2) and port 1 (w1=5, w2=7) → port 0 served first (`result`=125, done0). Port 1 is acked 2 cycles after done0 and completes with `result`=12 and done1.
- Fairness: both reqs held high for 4 ops → ack order 0,1,0,1, and each ack is followed by a done on the same port before the next ack.
- Zero-latency ALU: `alu_busy` never rises → RUN lasts exactly 2 cycles, then DONE with `result`=`alu_result`.
- Arg stability: change `w1_0` from 0x10 to 0x20 during RUN → `alu_w1` stays 0x10 until the next LAUNCH.
- Reset mid-RUN: `rst_n`=0 for one edge while busy → next cycle is IDLE, perm=0, `result`=0, no done. A subsequent req1 alone is granted normally.
